// File: rtl/intra16_pred_gen_pkg.sv
// Shared encodings and helpers for the luma 16x16 intra prediction generator.
package intra16_pred_gen_pkg;

  localparam logic [1:0] MODE_DC = 2'd0;
  localparam logic [1:0] MODE_TM = 2'd1;
  localparam logic [1:0] MODE_VE = 2'd2;
  localparam logic [1:0] MODE_HE = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SUM  = 4'b0010,
    ST_OUT  = 4'b0100,
    ST_FIN  = 4'b1000
  } state_e;

  localparam logic [7:0] DC_DEFAULT_C = 8'd128;
  localparam int         NUM_BEATS    = 64;
  localparam int         SUM_W        = 13;

  // v is left + top - corner in 10-bit two's complement (range -255..510).
  function automatic logic [7:0] clip255(input logic [9:0] v);
    if (v[9])      return 8'd0;
    else if (v[8]) return 8'd255;
    else           return v[7:0];
  endfunction

endpackage

// File: rtl/intra16_pred_gen_tm_row_clip.sv
// One TrueMotion prediction row: 16 parallel clip255(left + top[k] - corner) lanes.
module tm_row_clip
  import intra16_pred_gen_pkg::*;
(
  input  logic [7:0]   left_i,
  input  logic [127:0] top_i,
  input  logic [7:0]   corner_i,
  output logic [127:0] row_o
);

  for (genvar k = 0; k < 16; k++) begin : g_lane
    logic [9:0] sum;
    assign sum = {2'b00, left_i} + {2'b00, top_i[8*k +: 8]} - {2'b00, corner_i};
    assign row_o[8*k +: 8] = clip255(sum);
  end

endmodule

// File: rtl/intra16_pred_gen.sv
// Luma 16x16 intra prediction generator: streams DC, TM, VE, HE predictions
// as 64 row beats (mode outer, row inner) under a valid/ready handshake.
module intra16_pred_gen
  import intra16_pred_gen_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned DC_DEFAULT = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         has_top,
  input  logic         has_left,
  input  logic [127:0] top_y,
  input  logic [127:0] left_y,
  input  logic [7:0]   top_left_y,
  output logic         busy,
  output logic         pred_valid,
  input  logic         pred_ready,
  output logic [1:0]   pred_mode,
  output logic [3:0]   pred_row_idx,
  output logic [127:0] pred_row,
  output logic         done
);

  if (BLOCK_SIZE != 16) begin : g_bad_size
    $error("intra16_pred_gen: only BLOCK_SIZE=16 is supported");
  end

  localparam logic [7:0] DC_DEF    = 8'(DC_DEFAULT);
  localparam logic [5:0] LAST_BEAT = 6'(NUM_BEATS - 1);

  state_e             state_q, state_d;
  logic [5:0]         beat_q, beat_d;
  logic [127:0]       top_q, left_q;
  logic [7:0]         tl_q;
  logic               has_top_q, has_left_q;
  logic [SUM_W-1:0]   sum_top_q, sum_left_q;
  logic [SUM_W-1:0]   sum_top_d, sum_left_d;
  logic [7:0]         dc;
  logic [7:0]         left_byte;
  logic [127:0]       tm_row;
  logic [127:0]       row_d;
  logic [1:0]         mode;
  logic [3:0]         row_idx;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SUM;
          beat_d  = '0;
        end
      end
      ST_SUM: state_d = ST_OUT;
      ST_OUT: begin
        if (pred_ready) begin
          if (beat_q == LAST_BEAT) state_d = ST_FIN;
          else                     beat_d  = beat_q + 6'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // ---------------- Capture and neighbour sums ----------------
  always_comb begin
    sum_top_d  = '0;
    sum_left_d = '0;
    for (int k = 0; k < 16; k++) begin
      sum_top_d  = sum_top_d  + SUM_W'(top_q[8*k +: 8]);
      sum_left_d = sum_left_d + SUM_W'(left_q[8*k +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q      <= '0;
      left_q     <= '0;
      tl_q       <= '0;
      has_top_q  <= 1'b0;
      has_left_q <= 1'b0;
      sum_top_q  <= '0;
      sum_left_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        top_q      <= top_y;
        left_q     <= left_y;
        tl_q       <= top_left_y;
        has_top_q  <= has_top;
        has_left_q <= has_left;
      end
      if (state_q == ST_SUM) begin
        sum_top_q  <= sum_top_d;
        sum_left_q <= sum_left_d;
      end
    end
  end

  // Sums top out at 16*255 each, so the 13-bit adds below cannot overflow.
  always_comb begin
    case ({has_top_q, has_left_q})
      2'b11:   dc = 8'((sum_top_q + sum_left_q + 13'd16) >> 5);
      2'b10:   dc = 8'((sum_top_q + 13'd8) >> 4);
      2'b01:   dc = 8'((sum_left_q + 13'd8) >> 4);
      default: dc = DC_DEF;
    endcase
  end

  // ---------------- Beat datapath ----------------
  assign mode      = beat_q[5:4];
  assign row_idx   = beat_q[3:0];
  assign left_byte = left_q[{row_idx, 3'b000} +: 8];

  tm_row_clip u_tm (
    .left_i   (left_byte),
    .top_i    (top_q),
    .corner_i (tl_q),
    .row_o    (tm_row)
  );

  always_comb begin
    row_d = '0;
    if (state_q == ST_OUT) begin
      case (mode)
        MODE_DC: row_d = {16{dc}};
        MODE_TM: row_d = tm_row;
        MODE_VE: row_d = top_q;
        MODE_HE: row_d = {16{left_byte}};
        default: row_d = '0;
      endcase
    end
  end

  // Beat fields are zeroed outside OUT so idle/reset outputs read as 0.
  assign pred_valid   = (state_q == ST_OUT);
  assign pred_mode    = pred_valid ? mode    : 2'd0;
  assign pred_row_idx = pred_valid ? row_idx : 4'd0;
  assign pred_row     = row_d;
  assign busy         = (state_q == ST_SUM) || (state_q == ST_OUT);
  assign done         = (state_q == ST_FIN);

endmodule

// File: tb/tb_intra16_pred_gen.sv
// Directed + randomized bench for intra16_pred_gen with a behavioural prediction model.
module tb_intra16_pred_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         has_top, has_left;
  logic [127:0] top_y, left_y;
  logic [7:0]   top_left_y;
  logic         busy, pred_valid, pred_ready, done;
  logic [1:0]   pred_mode;
  logic [3:0]   pred_row_idx;
  logic [127:0] pred_row;

  always #5 clk = ~clk;

  intra16_pred_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .has_top      (has_top),
    .has_left     (has_left),
    .top_y        (top_y),
    .left_y       (left_y),
    .top_left_y   (top_left_y),
    .busy         (busy),
    .pred_valid   (pred_valid),
    .pred_ready   (pred_ready),
    .pred_mode    (pred_mode),
    .pred_row_idx (pred_row_idx),
    .pred_row     (pred_row),
    .done         (done)
  );

  int checks = 0;
  int fails  = 0;

  // Reference-model copy of the macroblock being streamed
  logic [127:0] m_top, m_left;
  logic [7:0]   m_tl;
  bit           m_ht, m_hl;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_row(input int m, input int r);
    int st, sl, dc, v;
    logic [127:0] row;
    st = 0; sl = 0; row = '0;
    for (int k = 0; k < 16; k++) begin
      st += int'(m_top[8*k +: 8]);
      sl += int'(m_left[8*k +: 8]);
    end
    if (m_ht && m_hl)  dc = (st + sl + 16) / 32;
    else if (m_ht)     dc = (st + 8) / 16;
    else if (m_hl)     dc = (sl + 8) / 16;
    else               dc = 128;
    for (int k = 0; k < 16; k++) begin
      case (m)
        0: row[8*k +: 8] = 8'(dc);
        1: begin
          v = int'(m_left[8*r +: 8]) + int'(m_top[8*k +: 8]) - int'(m_tl);
          if (v < 0) v = 0;
          if (v > 255) v = 255;
          row[8*k +: 8] = 8'(v);
        end
        2: row[8*k +: 8] = m_top[8*k +: 8];
        default: row[8*k +: 8] = m_left[8*r +: 8];
      endcase
    end
    return row;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 128'(pred_valid), 128'(0));
    chk({tag, ".busy"},  128'(busy), 128'(0));
    chk({tag, ".done"},  128'(done), 128'(0));
    chk({tag, ".mode"},  128'(pred_mode), 128'(0));
    chk({tag, ".idx"},   128'(pred_row_idx), 128'(0));
    chk({tag, ".row"},   pred_row, 128'(0));
  endtask

  // Issue one start and consume the stream; abort_at >= 0 pulses reset at that beat.
  task automatic run_mb(input string name, input logic [127:0] t, input logic [127:0] l,
                        input logic [7:0] c, input bit ht, input bit hl,
                        input bit rnd_ready, input int abort_at);
    int  b, cyc;
    bit  rdy, aborted;
    m_top = t; m_left = l; m_tl = c; m_ht = ht; m_hl = hl;
    @(negedge clk);
    top_y = t; left_y = l; top_left_y = c; has_top = ht; has_left = hl;
    start = 1'b1; pred_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the stream must come from the captured copy only
    top_y = rnd128(); left_y = rnd128(); top_left_y = 8'($urandom);
    has_top = 1'($urandom); has_left = 1'($urandom);
    chk({name, ".n1_valid"}, 128'(pred_valid), 128'(0));
    chk({name, ".n1_busy"},  128'(busy), 128'(1));
    @(negedge clk);
    b = 0; cyc = 0; aborted = 0;
    while (b < 64 && cyc < 2000 && !aborted) begin
      if (b == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle({name, ".rst"});
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
      end else begin
        rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        pred_ready = rdy;
        start = (b == 20);   // must be ignored while busy
        chk({name, ".valid"}, 128'(pred_valid), 128'(1));
        chk({name, ".busy"},  128'(busy), 128'(1));
        chk({name, ".done"},  128'(done), 128'(0));
        chk({name, ".mode"},  128'(pred_mode), 128'(b / 16));
        chk({name, ".idx"},   128'(pred_row_idx), 128'(b % 16));
        chk({name, ".row"},   pred_row, exp_row(b / 16, b % 16));
        @(negedge clk);
        cyc++;
        if (rdy) b++;
      end
    end
    start = 1'b0;
    if (aborted) begin
      repeat (3) begin
        chk_idle({name, ".post_rst"});
        @(negedge clk);
      end
    end else begin
      chk({name, ".beats"},     128'(b), 128'(64));
      chk({name, ".fin_valid"}, 128'(pred_valid), 128'(0));
      chk({name, ".fin_done"},  128'(done), 128'(1));
      chk({name, ".fin_busy"},  128'(busy), 128'(0));
      @(negedge clk);
      chk_idle({name, ".idle"});
    end
  endtask

  logic [127:0] ramp_top, ramp_left;

  initial begin
    rst_n = 1'b0; start = 1'b0; has_top = 1'b0; has_left = 1'b0;
    top_y = '0; left_y = '0; top_left_y = '0; pred_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("after_reset");

    for (int k = 0; k < 16; k++) begin
      ramp_top[8*k +: 8]  = 8'(k);
      ramp_left[8*k +: 8] = 8'(16 * k);
    end

    run_mb("both",      {16{8'd10}}, {16{8'd20}},  8'd15,  1, 1, 0, -1);
    run_mb("neither",   {16{8'd127}}, {16{8'd129}}, 8'd127, 0, 0, 0, -1);
    run_mb("tm_hi",     {16{8'd255}}, {16{8'd255}}, 8'd0,   1, 1, 0, -1);
    run_mb("tm_lo",     {16{8'd0}},   {16{8'd0}},   8'd255, 1, 1, 0, -1);
    run_mb("top_only",  ramp_top,     {16{8'd129}}, 8'd127, 1, 0, 0, -1);
    run_mb("left_only", {16{8'd127}}, ramp_left,    8'd127, 0, 1, 0, -1);
    run_mb("bp",        rnd128(), rnd128(), 8'($urandom), 1, 1, 1, -1);
    run_mb("abort",     rnd128(), rnd128(), 8'($urandom), 1, 1, 1, 30);
    run_mb("restart",   rnd128(), rnd128(), 8'($urandom), 1, 1, 0, -1);
    for (int i = 0; i < 4; i++)
      run_mb("rand", rnd128(), rnd128(), 8'($urandom),
             1'($urandom), 1'($urandom), 1, -1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
